// File: rtl/tap_shift_buffer.sv
// Tapped delay line of DEPTH samples (tap 0 = newest) with fill tracking, flush,
// full-ring recirculation and a registered random-access read port.
module tap_shift_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift,
    input  logic              rot,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              addr_err,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    localparam int unsigned LineW = DEPTH * DATA_W;

    // Stage k occupies bits [k*DATA_W +: DATA_W]; stage 0 sits in the low bits.
    logic [LineW-1:0]  stage_q, stage_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q;
    logic [DATA_W-1:0] dout_q;
    logic              dout_vld_q, addr_err_q;
    logic              in_range;

    // addr is never wider than count, so widening makes out-of-depth addresses fail too.
    assign in_range = CNT_W'(addr) < count_q;

    always_comb begin
        stage_d = stage_q;
        count_d = count_q;
        if (clr) begin
            stage_d = '0;
            count_d = '0;
        end else if (shift) begin
            stage_d = {stage_q[LineW-DATA_W-1:0], din};
            if (!full_q) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (rot && full_q) begin
            stage_d = {stage_q[LineW-DATA_W-1:0], stage_q[LineW-1 -: DATA_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q    <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            stage_q    <= stage_d;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_W'(DEPTH));
            dout_vld_q <= rd_en;
            addr_err_q <= rd_en && !in_range;
            // Reads see pre-update contents; dout holds when no read is issued.
            if (rd_en) begin
                dout_q <= in_range ? stage_q[addr*DATA_W +: DATA_W] : '0;
            end
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign addr_err = addr_err_q;
    assign count    = count_q;
    assign full     = full_q;

endmodule

// File: tb/tb_tap_shift_buffer.sv
// Directed self-checking bench for tap_shift_buffer (DATA_W=16, DEPTH=64).
module tb_tap_shift_buffer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CNT_W  = 7;

    logic              clk = 1'b0;
    logic              rst, shift, rot, clr, rd_en;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic              dout_vld, addr_err, full;
    logic [CNT_W-1:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    tap_shift_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .shift    (shift),
        .rot      (rot),
        .clr      (clr),
        .din      (din),
        .rd_en    (rd_en),
        .addr     (addr),
        .dout     (dout),
        .dout_vld (dout_vld),
        .addr_err (addr_err),
        .count    (count),
        .full     (full)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; shift = 0; rot = 0; clr = 0; rd_en = 0; din = '0; addr = '0;
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        shift = 1; din = v;
        tick();
        shift = 0;
    endtask

    task automatic read(input logic [ADDR_W-1:0] a);
        rd_en = 1; addr = a;
        tick();
        rd_en = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        n_cmp++;
        if (count !== 7'd0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_count: got count=%0d full=%0b, want 0/0", count, full);
        end
        n_cmp++;
        if (dout !== 16'h0 || dout_vld !== 1'b0 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_read: got dout=%h vld=%0b err=%0b, want 0000/0/0",
                     dout, dout_vld, addr_err);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) push(16'(i));
        n_cmp++;
        if (count !== 7'd5 || full !== 1'b0) begin
            n_err++;
            $display("FAIL fill_count: got count=%0d full=%0b, want 5/0", count, full);
        end
        read(6'd0);
        n_cmp++;
        if (dout !== 16'd5 || dout_vld !== 1'b1 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL fill_tap0: got dout=%h vld=%0b err=%0b, want 0005/1/0",
                     dout, dout_vld, addr_err);
        end
        read(6'd5);
        n_cmp++;
        if (dout !== 16'd0 || dout_vld !== 1'b1 || addr_err !== 1'b1) begin
            n_err++;
            $display("FAIL fill_tap5_err: got dout=%h vld=%0b err=%0b, want 0000/1/1",
                     dout, dout_vld, addr_err);
        end
        read(6'd4);
        n_cmp++;
        if (dout !== 16'd1 || dout_vld !== 1'b1 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL fill_tap4: got dout=%h vld=%0b err=%0b, want 0001/1/0",
                     dout, dout_vld, addr_err);
        end
        tick();
        n_cmp++;
        if (dout !== 16'd1 || dout_vld !== 1'b0 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL read_idle_hold: got dout=%h vld=%0b err=%0b, want 0001/0/0",
                     dout, dout_vld, addr_err);
        end
    endtask

    task automatic test_overflow();
        clr = 1;
        tick();
        clr = 0;
        n_cmp++;
        if (count !== 7'd0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL clr_count: got count=%0d full=%0b, want 0/0", count, full);
        end
        for (int i = 0; i < 64; i++) push(16'(i));
        n_cmp++;
        if (count !== 7'd64 || full !== 1'b1) begin
            n_err++;
            $display("FAIL fill_exact: got count=%0d full=%0b, want 64/1", count, full);
        end
        for (int i = 64; i < 70; i++) push(16'(i));
        n_cmp++;
        if (count !== 7'd64 || full !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_count: got count=%0d full=%0b, want 64/1", count, full);
        end
        read(6'd63);
        n_cmp++;
        if (dout !== 16'd6 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_tap63: got dout=%h err=%0b, want 0006/0", dout, addr_err);
        end
        read(6'd0);
        n_cmp++;
        if (dout !== 16'd69 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_tap0: got dout=%h err=%0b, want 0045/0", dout, addr_err);
        end
    endtask

    task automatic test_rot();
        rot = 1;
        tick();
        rot = 0;
        read(6'd0);
        n_cmp++;
        if (dout !== 16'd6) begin
            n_err++;
            $display("FAIL rot1_tap0: got %h want 0006", dout);
        end
        read(6'd1);
        n_cmp++;
        if (dout !== 16'd69) begin
            n_err++;
            $display("FAIL rot1_tap1: got %h want 0045", dout);
        end
        read(6'd63);
        n_cmp++;
        if (dout !== 16'd7 || count !== 7'd64) begin
            n_err++;
            $display("FAIL rot1_tap63: got dout=%h count=%0d want 0007/64", dout, count);
        end
        rot = 1;
        for (int i = 0; i < 63; i++) tick();
        rot = 0;
        read(6'd0);
        n_cmp++;
        if (dout !== 16'd69) begin
            n_err++;
            $display("FAIL rot64_tap0: got %h want 0045", dout);
        end
        read(6'd63);
        n_cmp++;
        if (dout !== 16'd6) begin
            n_err++;
            $display("FAIL rot64_tap63: got %h want 0006", dout);
        end
        read(6'd10);
        n_cmp++;
        if (dout !== 16'd59 || count !== 7'd64) begin
            n_err++;
            $display("FAIL rot64_tap10: got dout=%h count=%0d want 003b/64", dout, count);
        end
    endtask

    task automatic test_priority();
        shift = 1; rot = 1; din = 16'hAAAA;
        tick();
        shift = 0; rot = 0;
        read(6'd0);
        n_cmp++;
        if (dout !== 16'hAAAA || count !== 7'd64) begin
            n_err++;
            $display("FAIL shift_over_rot: got dout=%h count=%0d want aaaa/64", dout, count);
        end
        read(6'd1);
        n_cmp++;
        if (dout !== 16'd69) begin
            n_err++;
            $display("FAIL shift_over_rot_tap1: got %h want 0045", dout);
        end
        clr = 1; shift = 1; din = 16'hBEEF;
        tick();
        clr = 0; shift = 0;
        n_cmp++;
        if (count !== 7'd0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL clr_over_shift: got count=%0d full=%0b want 0/0", count, full);
        end
        push(16'd1); push(16'd2); push(16'd3);
        rot = 1;
        tick();
        rot = 0;
        read(6'd0);
        n_cmp++;
        if (dout !== 16'd3 || count !== 7'd3) begin
            n_err++;
            $display("FAIL rot_not_full_tap0: got dout=%h count=%0d want 0003/3", dout, count);
        end
        read(6'd2);
        n_cmp++;
        if (dout !== 16'd1 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL rot_not_full_tap2: got dout=%h err=%0b want 0001/0", dout, addr_err);
        end
    endtask

    task automatic test_same_cycle();
        rd_en = 1; addr = 6'd0; shift = 1; din = 16'h1234;
        tick();
        rd_en = 0; shift = 0;
        n_cmp++;
        if (dout !== 16'd3 || dout_vld !== 1'b1) begin
            n_err++;
            $display("FAIL read_with_shift: got dout=%h vld=%0b want 0003/1", dout, dout_vld);
        end
        read(6'd0);
        n_cmp++;
        if (dout !== 16'h1234 || count !== 7'd4) begin
            n_err++;
            $display("FAIL after_shift_tap0: got dout=%h count=%0d want 1234/4", dout, count);
        end
        rd_en = 1; addr = 6'd0; clr = 1;
        tick();
        rd_en = 0; clr = 0;
        n_cmp++;
        if (dout !== 16'h1234 || dout_vld !== 1'b1 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL read_with_clr: got dout=%h vld=%0b err=%0b want 1234/1/0",
                     dout, dout_vld, addr_err);
        end
        read(6'd0);
        n_cmp++;
        if (dout !== 16'd0 || addr_err !== 1'b1 || count !== 7'd0) begin
            n_err++;
            $display("FAIL after_clr_read: got dout=%h err=%0b count=%0d want 0000/1/0",
                     dout, addr_err, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_d [4];
        logic              exp_e [4];
        exp_d[0] = 16'd30; exp_d[1] = 16'd20; exp_d[2] = 16'd10; exp_d[3] = 16'd0;
        exp_e[0] = 1'b0;   exp_e[1] = 1'b0;   exp_e[2] = 1'b0;   exp_e[3] = 1'b1;
        push(16'd10); push(16'd20); push(16'd30);
        rd_en = 1;
        for (int i = 0; i < 4; i++) begin
            addr = 6'(i);
            tick();
            n_cmp++;
            if (dout !== exp_d[i] || dout_vld !== 1'b1 || addr_err !== exp_e[i]) begin
                n_err++;
                $display("FAIL b2b_read%0d: got dout=%h vld=%0b err=%0b want %h/1/%0b",
                         i, dout, dout_vld, addr_err, exp_d[i], exp_e[i]);
            end
        end
        rd_en = 0;
    endtask

    task automatic test_reset_mid();
        rd_en = 1; addr = 6'd0; rst = 1;
        tick();
        rd_en = 0; rst = 0;
        n_cmp++;
        if (dout_vld !== 1'b0 || count !== 7'd0 || dout !== 16'd0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got vld=%0b count=%0d dout=%h full=%0b want 0/0/0000/0",
                     dout_vld, count, dout, full);
        end
        push(16'd7);
        n_cmp++;
        if (count !== 7'd1) begin
            n_err++;
            $display("FAIL reset_then_shift: got count=%0d want 1", count);
        end
        read(6'd0);
        n_cmp++;
        if (dout !== 16'd7 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_then_read: got dout=%h err=%0b want 0007/0", dout, addr_err);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_overflow();
        test_rot();
        test_priority();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
